// File: rtl/hazard_scoreboard_pkg.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard_pkg
// Shared constants for the hazard scoreboard:
//   - 2-bit pause codes consumed by decode control (bit0 = rs, bit1 = rt)
//   - scoreboard entry field widths and stage indices
//   - pause_encode(): folds the two per-operand hazard bits into a pause code
// Optional build macro used by the files importing this package:
//   HAZARD_FORWARD_EN - hazard set reduces to load-use on the EX entry.
// -----------------------------------------------------------------------------
package hazard_scoreboard_pkg;

    typedef enum logic [1:0] {
        PAUSE_NO   = 2'b00,
        PAUSE_RS   = 2'b01,
        PAUSE_RT   = 2'b10,
        PAUSE_BOTH = 2'b11
    } pause_t;

    // Entry layout is {valid, addr[REG_AW], is_load}; addr width is a parameter.
    localparam int ENTRY_VALID_W = 1;
    localparam int ENTRY_LOAD_W  = 1;

    localparam int NUM_STAGES = 3;
    localparam int STAGE_EX   = 0;
    localparam int STAGE_MEM  = 1;
    localparam int STAGE_WB   = 2;

    function automatic int entry_width(input int reg_aw);
        return ENTRY_VALID_W + reg_aw + ENTRY_LOAD_W;
    endfunction

    function automatic pause_t pause_encode(input logic rs_haz, input logic rt_haz);
        pause_t code;
        case ({rt_haz, rs_haz})
            2'b00:   code = PAUSE_NO;
            2'b01:   code = PAUSE_RS;
            2'b10:   code = PAUSE_RT;
            2'b11:   code = PAUSE_BOTH;
            default: code = PAUSE_NO;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard_if
// Bundle between decode (master) and the hazard scoreboard (slave).
//   master drives : id_valid, id_rs, id_rt, id_reg_we, id_wreg, id_is_load,
//                   stall_req, flush
//   slave drives  : pause_code (combinational), stall_cnt (registered)
// -----------------------------------------------------------------------------
interface hazard_scoreboard_if #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
);
    logic              id_valid;
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic              id_reg_we;
    logic [REG_AW-1:0] id_wreg;
    logic              id_is_load;
    logic              stall_req;
    logic              flush;
    logic [1:0]        pause_code;
    logic [CNT_W-1:0]  stall_cnt;

    modport master (
        output id_valid, id_rs, id_rt, id_reg_we, id_wreg, id_is_load,
               stall_req, flush,
        input  pause_code, stall_cnt
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_reg_we, id_wreg, id_is_load,
               stall_req, flush,
        output pause_code, stall_cnt
    );
endinterface

// File: rtl/hazard_scoreboard_sb_match.sv
// -----------------------------------------------------------------------------
// sb_match
// Compares one scoreboard entry against one source register address.
//   e_valid/e_addr/e_is_load : the entry
//   src                      : source operand address from ID
//   match                    : entry writes src, src is not r0 and, when
//                              HAZARD_FORWARD_EN is defined, the entry is a load
// -----------------------------------------------------------------------------
module sb_match
    import hazard_scoreboard_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic              e_valid,
    input  logic [REG_AW-1:0] e_addr,
    input  logic              e_is_load,
    input  logic [REG_AW-1:0] src,
    output logic              match
);

    logic src_nz_s;
    logic load_ok_s;

`ifndef HAZARD_FORWARD_EN
    // Without forwarding every writer counts, so the load flag is not consulted.
    logic unused_is_load_s;
    assign unused_is_load_s = e_is_load;
`endif

    // Match qualification: r0 is hard-wired zero and never a dependence.
    always_comb begin
        src_nz_s = (src != {REG_AW{1'b0}});
`ifdef HAZARD_FORWARD_EN
        // With forwarding only a load's data arrives too late to bypass.
        load_ok_s = e_is_load;
`else
        load_ok_s = 1'b1;
`endif
        match = e_valid && src_nz_s && load_ok_s && (e_addr == src);
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard
// Tracks register writers in EX, MEM and WB and flags RAW hazards for the
// instruction in ID.
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   sb (slave) : ID operands/destination, stall_req/flush from decode control,
//                pause_code (combinational, bit0 rs / bit1 rt), stall_cnt
// Build option: HAZARD_FORWARD_EN - only a load in EX is a hazard (load-use);
// default build uses EX and MEM writers.
// -----------------------------------------------------------------------------
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    hazard_scoreboard_if.slave   sb
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [NUM_STAGES-1:0]             valid_q, valid_d;
    logic [NUM_STAGES-1:0][REG_AW-1:0] addr_q,  addr_d;
    logic [NUM_STAGES-1:0]             load_q,  load_d;
    logic [CNT_W-1:0]                  stall_cnt_q, stall_cnt_d;

    logic [NUM_STAGES-1:0] rs_match_s;
    logic [NUM_STAGES-1:0] rt_match_s;
    logic                  rs_haz_s;
    logic                  rt_haz_s;
    logic                  ex_fill_s;
    logic                  unused_match_s;

    // One comparator per (stage, operand) pair.
    for (genvar g = 0; g < NUM_STAGES; g++) begin : g_match
        sb_match #(.REG_AW(REG_AW)) u_rs (
            .e_valid   (valid_q[g]),
            .e_addr    (addr_q[g]),
            .e_is_load (load_q[g]),
            .src       (sb.id_rs),
            .match     (rs_match_s[g])
        );
        sb_match #(.REG_AW(REG_AW)) u_rt (
            .e_valid   (valid_q[g]),
            .e_addr    (addr_q[g]),
            .e_is_load (load_q[g]),
            .src       (sb.id_rt),
            .match     (rt_match_s[g])
        );
    end

    // Hazard set selection; WB never conflicts (write-before-read regfile).
    always_comb begin
`ifdef HAZARD_FORWARD_EN
        rs_haz_s       = rs_match_s[STAGE_EX];
        rt_haz_s       = rt_match_s[STAGE_EX];
        unused_match_s = ^{rs_match_s[STAGE_WB:STAGE_MEM], rt_match_s[STAGE_WB:STAGE_MEM]};
`else
        rs_haz_s       = rs_match_s[STAGE_EX] | rs_match_s[STAGE_MEM];
        rt_haz_s       = rt_match_s[STAGE_EX] | rt_match_s[STAGE_MEM];
        unused_match_s = rs_match_s[STAGE_WB] ^ rt_match_s[STAGE_WB];
`endif
    end

    // Pause code: zero-latency, gated by a real instruction in ID; stall_req
    // deliberately has no path here.
    always_comb begin
        sb.pause_code = pause_encode(rs_haz_s && sb.id_valid, rt_haz_s && sb.id_valid);
    end

    // Next-state: shift EX->MEM->WB and load EX from ID unless it is a bubble.
    always_comb begin
        valid_d = valid_q;
        addr_d  = addr_q;
        load_d  = load_q;

        valid_d[STAGE_WB]  = valid_q[STAGE_MEM];
        addr_d[STAGE_WB]   = addr_q[STAGE_MEM];
        load_d[STAGE_WB]   = load_q[STAGE_MEM];
        valid_d[STAGE_MEM] = valid_q[STAGE_EX];
        addr_d[STAGE_MEM]  = addr_q[STAGE_EX];
        load_d[STAGE_MEM]  = load_q[STAGE_EX];

        ex_fill_s = sb.id_valid && sb.id_reg_we && (sb.id_wreg != {REG_AW{1'b0}})
                    && !sb.stall_req && !sb.flush;

        if (ex_fill_s) begin
            valid_d[STAGE_EX] = 1'b1;
            addr_d[STAGE_EX]  = sb.id_wreg;
            load_d[STAGE_EX]  = sb.id_is_load;
        end else begin
            valid_d[STAGE_EX] = 1'b0;
            addr_d[STAGE_EX]  = {REG_AW{1'b0}};
            load_d[STAGE_EX]  = 1'b0;
        end
    end

    // Stall counter: a flushed stall is a single bubble, not a stall cycle;
    // saturates instead of wrapping.
    always_comb begin
        if (sb.stall_req && !sb.flush && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q     <= {NUM_STAGES{1'b0}};
            addr_q      <= '0;
            load_q      <= {NUM_STAGES{1'b0}};
            stall_cnt_q <= {CNT_W{1'b0}};
        end else begin
            valid_q     <= valid_d;
            addr_q      <= addr_d;
            load_q      <= load_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign sb.stall_cnt = stall_cnt_q;

endmodule
